// File: rtl/bra_rs_pkg.sv
// Shared definitions for the branch-unit reservation station.
// Holds the ROB tag width and the BRAOp encoding used by dispatch, the RS and BRA.
package bra_rs_pkg;

  localparam int ROB_ENTRY_WIDTH = 4;
  localparam int OP_W            = 4;

  // Code 0 means "no op". Dispatch never sends it, and on iss_op it idles BRA.
  typedef enum logic [OP_W-1:0] {
    BRA_NOP  = 4'd0,
    BRA_BEQ  = 4'd1,
    BRA_BNE  = 4'd2,
    BRA_BLT  = 4'd3,
    BRA_BGE  = 4'd4,
    BRA_BLTU = 4'd5,
    BRA_BGEU = 4'd6,
    BRA_JAL  = 4'd7,
    BRA_JALR = 4'd8
  } bra_op_e;

endpackage

// File: rtl/bra_rs_select.sv
// Oldest-ready selector and free-slot finder for the branch reservation station.
// Ports:
//   valid   in  RS_DEPTH            entry occupied
//   ready   in  RS_DEPTH            entry occupied with both operands present
//   older   in  RS_DEPTH x RS_DEPTH older[j][i]=1 -> entry j is older than entry i
//   grant   out RS_DEPTH            one-hot oldest ready entry (0 if none)
//   free_oh out RS_DEPTH            one-hot lowest-index free entry (0 if full)
module bra_rs_select
  import bra_rs_pkg::*;
#(
  parameter int RS_DEPTH = 4
)(
  input  logic [RS_DEPTH-1:0] valid,
  input  logic [RS_DEPTH-1:0] ready,
  input  logic [RS_DEPTH-1:0] older [RS_DEPTH],
  output logic [RS_DEPTH-1:0] grant,
  output logic [RS_DEPTH-1:0] free_oh
);

  always_comb begin
    logic blocked;
    logic found;
    grant   = '0;
    free_oh = '0;
    found   = 1'b0;
    blocked = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      // An entry wins only if no other ready entry is older than it.
      blocked = 1'b0;
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (j != i && ready[j] && older[j][i]) blocked = 1'b1;
      end
      grant[i] = ready[i] & ~blocked;
      if (!valid[i] && !found) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bra_rs.sv
// Reservation station in front of the branch unit (BRA).
// Buffers dispatched branch/jump ops until both sources are available, snoops the CDB
// for missing tags, and issues the oldest ready op per cycle on registered outputs.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   flush                      kill all entries and the issue register
//   disp_*                     dispatch request (op, sources with pending tags, pc, off, dest)
//   disp_ready                 out: RS not full
//   cdb_valid/cdb_tag/cdb_val  result broadcast
//   iss_*                      registered issue to BRA; iss_op = 0 means idle
module bra_rs
  import bra_rs_pkg::*;
#(
  parameter int RS_DEPTH = 4,
  parameter int TAG_W    = ROB_ENTRY_WIDTH,
  parameter int XLEN     = 32
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [OP_W-1:0]  disp_op,
  input  logic             disp_qj_v,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [XLEN-1:0]  disp_vj,
  input  logic             disp_qk_v,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic [XLEN-1:0]  disp_vk,
  input  logic [XLEN-1:0]  disp_pc,
  input  logic [XLEN-1:0]  disp_off,
  input  logic [TAG_W-1:0] disp_dest,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_val,
  output logic [OP_W-1:0]  iss_op,
  output logic [XLEN-1:0]  iss_srca,
  output logic [XLEN-1:0]  iss_srcb,
  output logic [XLEN-1:0]  iss_pc,
  output logic [XLEN-1:0]  iss_off,
  output logic [TAG_W-1:0] iss_dest
);

  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  logic [RS_DEPTH-1:0] valid, qj_v, qk_v;
  logic [OP_W-1:0]     op   [RS_DEPTH];
  logic [TAG_W-1:0]    qj   [RS_DEPTH];
  logic [TAG_W-1:0]    qk   [RS_DEPTH];
  logic [TAG_W-1:0]    dest [RS_DEPTH];
  logic [XLEN-1:0]     vj   [RS_DEPTH];
  logic [XLEN-1:0]     vk   [RS_DEPTH];
  logic [XLEN-1:0]     pc   [RS_DEPTH];
  logic [XLEN-1:0]     off  [RS_DEPTH];
  logic [RS_DEPTH-1:0] older [RS_DEPTH];

  logic [RS_DEPTH-1:0] ready, grant, free_oh, alloc, wake_j, wake_k;
  logic [IDX_W-1:0]    gidx;
  logic                disp_fire, byp_j, byp_k;

  assign ready      = valid & ~qj_v & ~qk_v;
  assign disp_ready = ~&valid;
  assign disp_fire  = disp_valid & disp_ready & ~flush;
  assign alloc      = disp_fire ? free_oh : '0;
  // A producer finishing on the CDB in the dispatch cycle would otherwise be missed.
  assign byp_j      = cdb_valid & disp_qj_v & (cdb_tag == disp_qj);
  assign byp_k      = cdb_valid & disp_qk_v & (cdb_tag == disp_qk);

  bra_rs_select #(.RS_DEPTH(RS_DEPTH)) u_select (
    .valid   (valid),
    .ready   (ready),
    .older   (older),
    .grant   (grant),
    .free_oh (free_oh)
  );

  always_comb begin
    gidx   = '0;
    wake_j = '0;
    wake_k = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (grant[i]) gidx = IDX_W'(i);
      wake_j[i] = cdb_valid & valid[i] & qj_v[i] & (cdb_tag == qj[i]);
      wake_k[i] = cdb_valid & valid[i] & qk_v[i] & (cdb_tag == qk[i]);
    end
  end

  // Entry control: occupancy, pending flags and age matrix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      qj_v  <= '0;
      qk_v  <= '0;
      for (int i = 0; i < RS_DEPTH; i++) older[i] <= '0;
    end else if (flush) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (alloc[i]) begin
          valid[i] <= 1'b1;
          qj_v[i]  <= disp_qj_v & ~byp_j;
          qk_v[i]  <= disp_qk_v & ~byp_k;
        end else begin
          if (grant[i])  valid[i] <= 1'b0;
          if (wake_j[i]) qj_v[i]  <= 1'b0;
          if (wake_k[i]) qk_v[i]  <= 1'b0;
        end
        // New entry: every currently valid entry is older than it, it is older than none.
        // Stale bits of freed entries are overwritten when the slot is reallocated.
        for (int j = 0; j < RS_DEPTH; j++) begin
          if (alloc[j])      older[i][j] <= valid[i];
          else if (alloc[i]) older[i][j] <= 1'b0;
        end
      end
    end
  end

  // Entry payload; only meaningful while the entry is valid, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (alloc[i]) begin
        op[i]   <= disp_op;
        qj[i]   <= disp_qj;
        qk[i]   <= disp_qk;
        vj[i]   <= byp_j ? cdb_val : disp_vj;
        vk[i]   <= byp_k ? cdb_val : disp_vk;
        pc[i]   <= disp_pc;
        off[i]  <= disp_off;
        dest[i] <= disp_dest;
      end else begin
        if (wake_j[i]) vj[i] <= cdb_val;
        if (wake_k[i]) vk[i] <= cdb_val;
      end
    end
  end

  // Issue register feeding BRA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_op   <= '0;
      iss_srca <= '0;
      iss_srcb <= '0;
      iss_pc   <= '0;
      iss_off  <= '0;
      iss_dest <= '0;
    end else if (flush) begin
      iss_op <= '0;
    end else if (|grant) begin
      iss_op   <= op[gidx];
      iss_srca <= vj[gidx];
      iss_srcb <= vk[gidx];
      iss_pc   <= pc[gidx];
      iss_off  <= off[gidx];
      iss_dest <= dest[gidx];
    end else begin
      iss_op <= '0;
    end
  end

endmodule
